// File: rtl/reg_file_sb.sv
// reg_file_sb: 32-entry register file with two combinational read ports,
// one write-back port, optional write-to-read forwarding and a pending-bit
// scoreboard that stalls consumers of registers awaiting a long-latency
// producer.
module reg_file_sb #(
   parameter int DATA_W = 32,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic              rtUsed,
   output logic [DATA_W-1:0] readData1,
   output logic [DATA_W-1:0] readData2,
   input  logic              regWrite,
   input  logic [4:0]        writeReg,
   input  logic [DATA_W-1:0] writeData,
   input  logic              issueValid,
   input  logic [4:0]        issueReg,
   output logic              stall,
   output logic [31:0]       pending
);

   localparam logic BYP_EN = (BYPASS != 0);

   logic [DATA_W-1:0] regs_q [32];
   logic [31:0]       pend_q;
   logic [31:0]       pend_d;
   logic              wr_en;
   logic              iss_en;
   logic              fwd_rs;
   logic              fwd_rt;
   logic              need_rs;
   logic              need_rt;

   // Index 0 is hard-wired: it is never written and never marked pending.
   assign wr_en  = regWrite && (writeReg != 5'd0);
   assign iss_en = issueValid && (issueReg != 5'd0);

   // A write-back in flight matches a read index; only meaningful when
   // forwarding is enabled, otherwise reads see the pre-write value and the
   // write-back does not release a stall until the pending bit clears.
   assign fwd_rs = BYP_EN && wr_en && (writeReg == rs);
   assign fwd_rt = BYP_EN && wr_en && (writeReg == rt);

   // Select between forwarded write data and stored contents for one port.
   function automatic logic [DATA_W-1:0] read_port(
      input logic [4:0]        idx,
      input logic [DATA_W-1:0] stored,
      input logic              fwd,
      input logic [DATA_W-1:0] wdata
   );
      logic [DATA_W-1:0] val;
      if (idx == 5'd0) begin
         val = '0;
      end else if (fwd) begin
         val = wdata;
      end else begin
         val = stored;
      end
      return val;
   endfunction

   // An operand stalls when its register is pending and no forwarded
   // write-back is satisfying it this cycle.
   function automatic logic operand_wait(
      input logic [4:0]  idx,
      input logic [31:0] pend,
      input logic        released
   );
      return (idx != 5'd0) && pend[idx] && !released;
   endfunction

   // Register storage: cleared by reset, written on write-back strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         regs_q[writeReg] <= writeData;
      end
   end

   // Scoreboard next state: clear on write-back, then set on issue so a new
   // producer to the same index supersedes the completing one.
   always_comb begin
      pend_d = pend_q;
      if (wr_en) begin
         pend_d[writeReg] = 1'b0;
      end
      if (iss_en) begin
         pend_d[issueReg] = 1'b1;
      end
      pend_d[0] = 1'b0;
   end

   // Scoreboard state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign pending = pend_q;

   // Read ports and hazard detection; all forced quiet while in reset.
   always_comb begin
      readData1 = '0;
      readData2 = '0;
      need_rs   = 1'b0;
      need_rt   = 1'b0;
      stall     = 1'b0;
      if (!rst) begin
         readData1 = read_port(rs, regs_q[rs], fwd_rs, writeData);
         readData2 = read_port(rt, regs_q[rt], fwd_rt, writeData);
         need_rs   = operand_wait(rs, pend_q, fwd_rs);
         need_rt   = rtUsed && operand_wait(rt, pend_q, fwd_rt);
         stall     = need_rs || need_rt;
      end
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed and random checks of reg_file_sb with forwarding
// enabled (instance a) and disabled (instance b) against an array model.
module tb_reg_file_sb;

   logic        clk;
   logic        rst;
   logic [4:0]  rs, rt, writeReg, issueReg;
   logic        rtUsed, regWrite, issueValid;
   logic [31:0] writeData;

   logic [31:0] rd1_a, rd2_a, pend_a;
   logic [31:0] rd1_b, rd2_b, pend_b;
   logic        stall_a, stall_b;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] m_regs [32];
   logic [31:0] m_pend;

   reg_file_sb #(.DATA_W(32), .BYPASS(1)) dut_a (
      .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rtUsed(rtUsed),
      .readData1(rd1_a), .readData2(rd2_a),
      .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
      .issueValid(issueValid), .issueReg(issueReg),
      .stall(stall_a), .pending(pend_a)
   );

   reg_file_sb #(.DATA_W(32), .BYPASS(0)) dut_b (
      .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rtUsed(rtUsed),
      .readData1(rd1_b), .readData2(rd2_b),
      .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
      .issueValid(issueValid), .issueReg(issueReg),
      .stall(stall_b), .pending(pend_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_read(input logic [4:0] idx, input bit fwd_on);
      if (rst || idx == 0) return 32'h0;
      if (fwd_on && regWrite && writeReg == idx) return writeData;
      return m_regs[idx];
   endfunction

   function automatic logic exp_stall(input bit fwd_on);
      bit w1, w2;
      if (rst) return 1'b0;
      w1 = (rs != 0) && m_pend[rs] && !(fwd_on && regWrite && writeReg == rs);
      w2 = rtUsed && (rt != 0) && m_pend[rt] && !(fwd_on && regWrite && writeReg == rt);
      return w1 || w2;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_pend = 32'h0;
   endtask

   // Compare every output of both instances against the model.
   task automatic check_all(input string tag);
      if (rst) model_clear();
      check({tag, ".rd1_a"},   rd1_a,          exp_read(rs, 1'b1));
      check({tag, ".rd2_a"},   rd2_a,          exp_read(rt, 1'b1));
      check({tag, ".stall_a"}, {31'h0, stall_a}, {31'h0, exp_stall(1'b1)});
      check({tag, ".pend_a"},  pend_a,         m_pend);
      check({tag, ".rd1_b"},   rd1_b,          exp_read(rs, 1'b0));
      check({tag, ".rd2_b"},   rd2_b,          exp_read(rt, 1'b0));
      check({tag, ".stall_b"}, {31'h0, stall_b}, {31'h0, exp_stall(1'b0)});
      check({tag, ".pend_b"},  pend_b,         m_pend);
   endtask

   // Inputs are applied just after a falling edge; check, then clock.
   task automatic cycle(input string tag);
      #1;
      check_all(tag);
      @(posedge clk);
      if (!rst) begin
         if (regWrite && writeReg != 0) begin
            m_regs[writeReg] = writeData;
            m_pend[writeReg] = 1'b0;
         end
         if (issueValid && issueReg != 0) m_pend[issueReg] = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic idle();
      regWrite = 0; writeReg = 0; writeData = 0;
      issueValid = 0; issueReg = 0;
   endtask

   initial begin
      model_clear();
      rst = 1; rs = 0; rt = 0; rtUsed = 1;
      idle();
      @(negedge clk);
      cycle("reset");
      rst = 0;
      cycle("post_reset");

      // Write then read back; index 0 reads 0.
      regWrite = 1; writeReg = 5; writeData = 32'hDEADBEEF; rs = 5;
      cycle("wr5");
      idle(); rs = 5;
      #1;
      check("rd5_literal", rd1_a, 32'hDEADBEEF);
      check("rd5_literal_b", rd1_b, 32'hDEADBEEF);
      cycle("rd5");
      rs = 0;
      cycle("rd0");

      // Zero register and zero-index issue.
      regWrite = 1; writeReg = 0; writeData = 32'h12345678; rs = 0;
      cycle("wr0");
      idle(); issueValid = 1; issueReg = 0;
      cycle("iss0");
      idle();
      #1;
      check("zero_rd", rd1_a, 32'h0);
      check("zero_pend", pend_a, 32'h0);
      cycle("zero_after");

      // Forwarding versus pre-write value.
      regWrite = 1; writeReg = 7; writeData = 32'h11111111;
      cycle("wr7_old");
      regWrite = 1; writeReg = 7; writeData = 32'hA5A5A5A5; rt = 7;
      #1;
      check("byp_a", rd2_a, 32'hA5A5A5A5);
      check("byp_b", rd2_b, 32'h11111111);
      cycle("byp");
      idle();

      // Load-use stall.
      issueValid = 1; issueReg = 9; rs = 0; rt = 0;
      cycle("iss9");
      idle(); rs = 9;
      #1;
      check("lu_stall", {31'h0, stall_a}, 32'h1);
      cycle("lu_rs");
      rs = 1; rt = 9; rtUsed = 0;
      cycle("lu_imm");
      rtUsed = 1;
      cycle("lu_rt");
      rs = 9; regWrite = 1; writeReg = 9; writeData = 32'h00C0FFEE;
      #1;
      check("wb_release_a", {31'h0, stall_a}, 32'h0);
      check("wb_hold_b", {31'h0, stall_b}, 32'h1);
      cycle("lu_wb");
      idle();
      #1;
      check("pend9_clear", {31'h0, pend_a[9]}, 32'h0);
      cycle("lu_done");

      // Same-cycle set/clear.
      issueValid = 1; issueReg = 4;
      cycle("iss4");
      issueValid = 1; issueReg = 4; regWrite = 1; writeReg = 4; writeData = 32'h44;
      cycle("set_clr_same");
      idle();
      #1;
      check("pend4_set_wins", {31'h0, pend_a[4]}, 32'h1);
      issueValid = 1; issueReg = 3; regWrite = 1; writeReg = 4; writeData = 32'h444;
      cycle("set_clr_diff");
      idle();
      #1;
      check("pend34", {30'h0, pend_a[4], pend_a[3]}, 32'h1);
      cycle("set_clr_after");

      // Asynchronous reset in the middle of a cycle.
      issueValid = 1; issueReg = 9;
      cycle("iss9b");
      issueReg = 10; regWrite = 1; writeReg = 3; writeData = 32'h33;
      cycle("iss10");
      idle(); rs = 9; rt = 10;
      #1;
      check("pend_600", pend_a & 32'h0000_0600, 32'h0000_0600);
      regWrite = 1; writeReg = 5; writeData = 32'hFFFF0000;
      issueValid = 1; issueReg = 12;
      #1;
      rst = 1;
      #1;
      check("async_pend", pend_a, 32'h0);
      check("async_stall", {31'h0, stall_a}, 32'h0);
      check("async_rd1", rd1_a, 32'h0);
      check("async_rd2", rd2_b, 32'h0);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rs = 5'($urandom); rt = 5'($urandom);
         regWrite = 1; writeReg = 5'($urandom); writeData = $urandom;
         issueValid = 1; issueReg = 5'($urandom);
         cycle("in_reset");
      end
      rst = 0; idle(); rs = 5; rt = 9;
      cycle("post_async");

      // Random traffic; small index range to provoke hazards and forwarding.
      for (int i = 0; i < 400; i++) begin
         rst        = ($urandom_range(0, 59) == 0);
         rs         = 5'($urandom_range(0, 7));
         rt         = 5'($urandom_range(0, 7));
         rtUsed     = 1'($urandom);
         regWrite   = 1'($urandom);
         writeReg   = 5'($urandom_range(0, 7));
         writeData  = $urandom;
         issueValid = ($urandom_range(0, 2) == 0);
         issueReg   = 5'($urandom_range(0, 7));
         cycle("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter: DATA_W, 32, register and data width in bits.
REQ-002 Parameter: BYPASS, 1, write-to-read forwarding enable (1 = forward, 0 = no forward).
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: rs  input  5  read-port-1 register index.
REQ-006 Port: rt  input  5  read-port-2 register index.
REQ-007 Port: rtUsed  input  1  1 = current instruction consumes rt (register operand); 0 = immediate operand selected downstream.
REQ-008 Port: readData1  output  DATA_W  register rs contents.
REQ-009 Port: readData2  output  DATA_W  register rt contents; feeds the ALU operand-b select.
REQ-010 Port: regWrite  input  1  write-back strobe.
REQ-011 Port: writeReg  input  5  write-back destination index.
REQ-012 Port: writeData  input  DATA_W  write-back data.
REQ-013 Port: issueValid  input  1  a long-latency producer (load) has been issued this cycle.
REQ-014 Port: issueReg  input  5  destination index of the issued producer.
REQ-015 Port: stall  output  1  an operand is pending, so the consumer shall hold.
REQ-016 Port: pending  output  32  scoreboard vector; bit i = register i awaiting write-back.

Function
REQ-017 The block SHALL hold 32 registers of DATA_W bits, indexed 0-31.
REQ-018 Register 0 SHALL always read 0; writes to index 0 SHALL be ignored.
REQ-019 Write: on a rising clk edge with regWrite=1 and writeReg!=0, reg[writeReg] SHALL take writeData; it is visible to non-bypassed reads from the next cycle.
REQ-020 Reads SHALL be combinational: readData1 = reg[rs], readData2 = reg[rt], with zero latency.
REQ-021 With BYPASS=1, when regWrite=1, writeReg!=0 and writeReg equals rs (or rt), the matching readData output SHALL equal writeData in the same cycle.
REQ-022 With BYPASS=0, same-cycle reads SHALL return the pre-write value.
REQ-023 Scoreboard set: on a rising edge with issueValid=1 and issueReg!=0, pending[issueReg] SHALL become 1.
REQ-024 Scoreboard clear: on a rising edge with regWrite=1 and writeReg!=0, pending[writeReg] SHALL become 0.
REQ-025 If set and clear target the same index in one cycle, set SHALL win and the bit ends at 1, because the new producer supersedes the old one.
REQ-026 Set and clear on different indices in one cycle SHALL both take effect.
REQ-027 pending[0] SHALL be constant 0.
REQ-028 stall SHALL be asserted when the following expression is 1: (rs!=0 and pending[rs] and not clr_rs) or (rtUsed and rt!=0 and pending[rt] and not clr_rt).
REQ-029 In REQ-028, clr_x means that in this same cycle regWrite=1 and writeReg=x. With BYPASS=1 a write-back in flight releases the stall combinationally; with BYPASS=0 clr_x SHALL be forced to 0.
REQ-030 stall SHALL be purely combinational from current state and inputs; the block SHALL NOT register stall.
REQ-031 Write-back to a register whose pending bit is 0 SHALL be legal; it updates data and leaves the bit at 0.

Reset
REQ-032 While rst=1, asynchronously and regardless of clk, all registers SHALL read 0 and pending SHALL be 0.
REQ-033 While rst=1, stall SHALL be 0 and readData1/readData2 SHALL be 0.
REQ-034 While rst=1, writes and issues SHALL be ignored.
REQ-035 Reset asserted mid-operation (pending bits set, write in progress) SHALL discard all state; the first edge after rst deasserts SHALL behave as from power-up.

Verification
REQ-036 Reset then write: rst pulse; write reg5=0xDEADBEEF; rs=5 next cycle -> readData1=0xDEADBEEF; rs=0 -> readData1=0.
REQ-037 Zero register: write reg0=0x12345678 -> readData1 with rs=0 stays 0; pending[0] stays 0 after issueReg=0.
REQ-038 Bypass: BYPASS=1, regWrite=1, writeReg=7, writeData=0xA5A5A5A5, rt=7 in same cycle -> readData2=0xA5A5A5A5; BYPASS=0 -> old value.
REQ-039 Load-use stall: issue reg9; next cycle rs=9 -> stall=1; rtUsed=0 with rt=9, rs=1 -> stall=0; write-back reg9 -> stall drops in write-back cycle (BYPASS=1), pending[9]=0 after edge.
REQ-040 Same-cycle set and clear: pending[4]=1; issueReg=4 with regWrite to reg4 on one edge -> pending[4]=1 afterwards; different indices (issue 3, write 4) -> pending[3]=1, pending[4]=0.
REQ-041 Async reset mid-op: pending=0x0000_0600, assert rst between edges -> pending=0, stall=0, all reads 0 immediately.
